// File: rtl/ped_request_cond.sv
// Pedestrian push-button conditioner: sync, debounce, press strobe,
// sticky request with acknowledge, and a saturating 2-digit BCD request count.
module ped_request_cond #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic       clk_50MHz,
  input  logic       reset,
  input  logic       key_n,
  input  logic       ack,
  output logic       key_level,
  output logic       key_pulse,
  output logic       req,
  output logic [7:0] req_count
);

  localparam logic [CNT_W-1:0] LP_CNT_MAX =
    CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [7:0] LP_COUNT_SAT = 8'h99;

  logic             r_s1;
  logic             r_s2;
  logic             r_stable;
  logic             r_stable_d;
  logic [CNT_W-1:0] r_cnt;
  logic             r_key_level;
  logic             r_key_pulse;
  logic             r_req;
  logic [7:0]       r_count;

  logic             w_diff;
  logic             w_done;
  logic             w_accept;
  logic [7:0]       w_count_next;

  assign w_diff   = (r_s2 != r_stable);
  assign w_done   = w_diff && (r_cnt == LP_CNT_MAX);
  // A press is a new request unless it merges into one still pending.
  assign w_accept = r_key_pulse & (~r_req | ack);

  always_comb begin
    w_count_next = r_count;
    if (r_count != LP_COUNT_SAT) begin
      if (r_count[3:0] == 4'd9) begin
        w_count_next[3:0] = 4'd0;
        w_count_next[7:4] = r_count[7:4] + 4'd1;
      end else begin
        w_count_next[3:0] = r_count[3:0] + 4'd1;
      end
    end
  end

  always_ff @(posedge clk_50MHz) begin
    if (reset) begin
      r_s1 <= 1'b1;
      r_s2 <= 1'b1;
    end else begin
      r_s1 <= key_n;
      r_s2 <= r_s1;
    end
  end

  always_ff @(posedge clk_50MHz) begin
    if (reset) begin
      r_stable <= 1'b1;
      r_cnt    <= '0;
    end else if (!w_diff) begin
      r_cnt <= '0;
    end else if (w_done) begin
      r_stable <= r_s2;
      r_cnt    <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // r_stable_d lets the strobe fire on the 1->0 edge of the accepted level.
  always_ff @(posedge clk_50MHz) begin
    if (reset) begin
      r_stable_d  <= 1'b1;
      r_key_level <= 1'b0;
      r_key_pulse <= 1'b0;
    end else begin
      r_stable_d  <= r_stable;
      r_key_level <= ~r_stable;
      r_key_pulse <= r_stable_d & ~r_stable;
    end
  end

  always_ff @(posedge clk_50MHz) begin
    if (reset) begin
      r_req   <= 1'b0;
      r_count <= 8'h00;
    end else begin
      r_req <= r_key_pulse | (r_req & ~ack);
      if (w_accept) begin
        r_count <= w_count_next;
      end
    end
  end

  assign key_level = r_key_level;
  assign key_pulse = r_key_pulse;
  assign req       = r_req;
  assign req_count = r_count;

endmodule

// File: doc/ped_request_cond.md
Name: ped_request_cond

Overview:
- Upstream input conditioner for the traffic-light controller state machine.
- Takes the raw, bouncy, asynchronous pedestrian push-button (active-low) and synchronises and debounces it.
- Produces a clean press pulse and a sticky request flag, which the controller clears with an acknowledge when it enters the serving phase.
- Also keeps a 2-digit BCD count of accepted requests, formatted to drop straight into one byte of the 7-segment display data word.

Parameters:
- DEBOUNCE_CYCLES, 1000000, number of consecutive clk_50MHz cycles the synchronised input must differ from the stable level before the change is accepted (20 ms at 50 MHz); must be >= 2.
- CNT_W, 20, width of the debounce counter; must hold DEBOUNCE_CYCLES-1.

Ports:
- clk_50MHz  input  1  system clock; the block's only clock.
- reset  input  1  synchronous, active-high reset.
- key_n  input  1  raw pedestrian button; asynchronous; 0 = pressed.
- ack  input  1  request acknowledge from controller; sampled every cycle; pulse or level.
- key_level  output  1  debounced button level; 1 = pressed.
- key_pulse  output  1  one-cycle strobe on each debounced press (release edge gives no strobe).
- req  output  1  sticky pending-request flag.
- req_count  output  8  accepted-request count, BCD: [7:4] tens, [3:0] units.

Behaviour:
- One clock; all state updates on posedge clk_50MHz. Reset is synchronous, active-high, and overrides everything else in the same cycle.
- Reset values:
  - sync flops = 1 (idle).
  - stable = 1.
  - debounce counter = 0.
  - key_level = 0, key_pulse = 0, req = 0, req_count = 8'h00.
- Synchroniser:
  - Two-flop chain s1 <= key_n, s2 <= s1.
  - Only s2 is used downstream.
- Debounce:
  - stable holds the accepted level of key_n.
  - If s2 == stable, the counter is cleared to 0.
  - Otherwise the counter increments.
  - When the counter == DEBOUNCE_CYCLES-1 and s2 != stable: stable <= s2 and the counter is cleared.
  - Any bounce back to s2 == stable before then restarts the count from 0.
- key_level = ~stable, registered.
- key_pulse:
  - Asserted for exactly the one cycle after stable transitions 1->0.
  - Never asserted on a 0->1 transition.
  - Never asserted on two consecutive cycles.
- Latency: a clean press (key_n falls and stays low) raises key_pulse and key_level DEBOUNCE_CYCLES+3 clock edges after the first edge that samples key_n = 0. Release latency is identical for key_level.
- req:
  - Next value = key_pulse | (req & ~ack).
  - ack clears req.
  - key_pulse and ack in the same cycle leaves req = 1: the press counts as a new request arriving during service.
  - ack while req = 0 has no effect.
  - key_pulse while req = 1 (and no ack) merges; req stays 1.
- req_count:
  - Increments by 1 (BCD) on a cycle where key_pulse = 1 and (req = 0 or ack = 1), i.e. when a new request is accepted.
  - Merged presses are not counted.
  - Units digit wraps 9 -> 0 with a carry into tens.
  - Saturates at 8'h99 and holds there.
  - Cleared only by reset.
  - Nibbles are never above 9.
- Reset mid-operation (during debounce, with req pending, or with the key held):
  - All state returns to the reset values.
  - A key still held low after reset is re-debounced from scratch and produces exactly one key_pulse, DEBOUNCE_CYCLES+3 edges after reset deasserts.
- Outputs are registered; there is no combinational path from key_n or ack to any output.

Test Plan:
All scenarios use DEBOUNCE_CYCLES = 4.
- Reset and idle: assert reset for 3 cycles with key_n = 1 -> all outputs 0, req_count = 8'h00; no activity for 50 cycles.
- Clean press: key_n goes to 0 and holds -> key_pulse high for exactly 1 cycle, 7 edges after the first low sample; key_level = 1 from then on; req = 1; req_count = 8'h01. Release -> key_level = 0 after 7 edges, no pulse.
- Bounce rejection: key_n toggles 0/1 every 2 cycles for 40 cycles, then settles at 1 -> no key_pulse; key_level stays 0; req_count unchanged.
- Handshake:
  - Press, then ack = 1 for 1 cycle -> req = 0.
  - Second press with no ack -> req = 1, req_count = 8'h02.
  - Third press before ack (merged) -> req_count stays 8'h02.
  - Press coincident with an ack cycle -> req stays 1, req_count = 8'h03.
- BCD and saturation: 9 accepted requests (each acked) -> req_count = 8'h09; the 10th gives 8'h10; 105 total gives 8'h99 and it holds.
- Reset mid-debounce: key_n = 0, then reset asserted 2 cycles into debounce while key_n is held -> no pulse during reset; exactly one key_pulse 7 edges after reset deasserts; req_count = 8'h01.
